// File: rtl/keystream_if.sv
// keystream_if: start/mantissa/key-byte handshake bundle for keystream_gen.
interface keystream_if;
    logic        start;
    logic [17:0] num_bytes;
    logic        ex_valid;
    logic [22:0] EX1, EX2, EX3;
    logic        ex_ready;
    logic [7:0]  key_byte;
    logic        key_valid;
    logic        key_ready;
    logic        busy;
    logic        done;
    modport master (output start, num_bytes, ex_valid, EX1, EX2, EX3, key_ready,
                    input  ex_ready, key_byte, key_valid, busy, done);
    modport slave  (input  start, num_bytes, ex_valid, EX1, EX2, EX3, key_ready,
                    output ex_ready, key_byte, key_valid, busy, done);
endinterface

// File: rtl/keystream_gen.sv
// keystream_gen: folds chaotic-map mantissa triples into key bytes behind a 4-entry show-ahead FIFO.
module keystream_gen (
    input logic        clk,
    input logic        rst,
    keystream_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EMIT, FLUSH} state_t;
    state_t           state, state_nx;
    logic [17:0]      remaining;
    logic [1:0]       idx, wr_ptr, rd_ptr;
    logic [2:0]       count;
    logic [2:0][7:0]  k;
    logic [3:0][7:0]  mem;
    logic             done_q, done_nx, push, pop, accept;
    // push sees the pre-pop count, so a full FIFO blocks even when draining
    assign push   = state == EMIT && count < 3'd4;
    assign pop    = bus.key_valid && bus.key_ready;
    assign accept = state == FETCH && bus.ex_valid;
    assign bus.ex_ready  = state == FETCH;
    assign bus.key_valid = count != 3'd0;
    assign bus.key_byte  = bus.key_valid ? mem[rd_ptr] : 8'h00;
    assign bus.busy      = state != IDLE;
    assign bus.done      = done_q;
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && bus.num_bytes != 18'd0) state_nx = FETCH;
                done_nx = bus.start && bus.num_bytes == 18'd0;
            end
            FETCH: if (bus.ex_valid) state_nx = EMIT;
            EMIT: if (push) state_nx = remaining == 18'd1 ? FLUSH : idx == 2'd2 ? FETCH : EMIT;
            FLUSH: if (count == 3'd0) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            remaining <= '0;
            idx       <= '0;
            k         <= '0;
            mem       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state  <= state_nx;
            done_q <= done_nx;
            if (state == IDLE && bus.start) remaining <= bus.num_bytes;
            if (accept) begin
                k[0] <= bus.EX1[7:0] ^ bus.EX2[15:8] ^ bus.EX3[22:15];
                k[1] <= bus.EX2[7:0] ^ bus.EX3[15:8] ^ bus.EX1[22:15];
                k[2] <= bus.EX3[7:0] ^ bus.EX1[15:8] ^ bus.EX2[22:15];
                idx  <= '0;
            end
            if (push) begin
                mem[wr_ptr] <= k[idx];
                wr_ptr      <= wr_ptr + 2'd1;
                remaining   <= remaining - 18'd1;
                idx         <= idx + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(push) - 3'(pop);
        end
    end
endmodule

// File: tb/tb_keystream_gen.sv
// tb_keystream_gen: directed scenarios for keystream_gen with hand-computed key bytes.
module tb_keystream_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    keystream_if bus ();
    keystream_gen dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    logic [7:0] got[$];
    int n_acc, n_exr, n_done, done_cyc;
    bit timed_out;
    // EX1=0x123456, EX2=0x654321, EX3=0x0ABCDE gives K0=00 K1=B9 K2=20, repeating per triple
    logic [7:0] seq [7] = '{8'h00, 8'hB9, 8'h20, 8'h00, 8'hB9, 8'h20, 8'h00};

    task automatic clear();
        got.delete();
        n_acc = 0; n_exr = 0; n_done = 0; done_cyc = -1;
    endtask

    task automatic do_start(input logic [17:0] nb);
        bus.num_bytes = nb;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run(input int max_cyc, input int inj);
        timed_out = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            if (bus.key_valid && bus.key_ready) got.push_back(bus.key_byte);
            if (bus.ex_ready) n_exr++;
            if (bus.ex_valid && bus.ex_ready) n_acc++;
            if (bus.done) begin n_done++; done_cyc = c; timed_out = 1'b0; break; end
            bus.start = (c == inj);
            if (c == inj) bus.num_bytes = 18'd5;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid got %b exp 0", bus.key_valid); end
        checks++; if (bus.key_byte !== 8'h00) begin errors++; $display("FAIL rst_key_byte got %h exp 00", bus.key_byte); end
        checks++; if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL rst_ex_ready got %b exp 0", bus.ex_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_basic();
        clear();
        do_start(18'd3);
        run(50, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got no done exp done"); end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL basic_len got %0d exp 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got.size() <= i || got[i] !== seq[i]) begin errors++; $display("FAIL basic_byte%0d got %h exp %h", i, got.size() > i ? got[i] : 8'hxx, seq[i]); end
        end
        checks++; if (n_acc !== 1) begin errors++; $display("FAIL basic_triples got %0d exp 1", n_acc); end
        checks++; if (done_cyc !== 6) begin errors++; $display("FAIL basic_done_cycle got %0d exp 6", done_cyc); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", bus.busy); end
    endtask

    task automatic test_truncate();
        clear();
        do_start(18'd2);
        run(50, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL trunc_timeout got no done exp done"); end
        checks++; if (got.size() !== 2) begin errors++; $display("FAIL trunc_len got %0d exp 2", got.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (got.size() <= i || got[i] !== seq[i]) begin errors++; $display("FAIL trunc_byte%0d got %h exp %h", i, got.size() > i ? got[i] : 8'hxx, seq[i]); end
        end
        checks++; if (n_exr !== 1) begin errors++; $display("FAIL trunc_ex_ready_cycles got %0d exp 1", n_exr); end
        checks++; if (done_cyc !== 5) begin errors++; $display("FAIL trunc_done_cycle got %0d exp 5", done_cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        do_start(18'd0);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", bus.busy); end
        checks++; if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL zero_ex_ready got %b exp 0", bus.ex_ready); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_drop got %b exp 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after got %b exp 0", bus.busy); end
    endtask

    task automatic test_stall();
        bus.key_ready = 1'b0;
        clear();
        do_start(18'd7);
        run(12, -1);
        checks++; if (!timed_out) begin errors++; $display("FAIL stall_early_done got done exp none"); end
        checks++; if (n_acc !== 2) begin errors++; $display("FAIL stall_triples got %0d exp 2", n_acc); end
        checks++; if (bus.key_valid !== 1'b1) begin errors++; $display("FAIL stall_key_valid got %b exp 1", bus.key_valid); end
        checks++; if (bus.key_byte !== 8'h00) begin errors++; $display("FAIL stall_key_byte got %h exp 00", bus.key_byte); end
        checks++; if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL stall_ex_ready got %b exp 0", bus.ex_ready); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b exp 1", bus.busy); end
        bus.key_ready = 1'b1;
        run(100, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout got no done exp done"); end
        checks++; if (got.size() !== 7) begin errors++; $display("FAIL stall_len got %0d exp 7", got.size()); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (got.size() <= i || got[i] !== seq[i]) begin errors++; $display("FAIL stall_byte%0d got %h exp %h", i, got.size() > i ? got[i] : 8'hxx, seq[i]); end
        end
        checks++; if (n_acc !== 3) begin errors++; $display("FAIL stall_total_triples got %0d exp 3", n_acc); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        clear();
        do_start(18'd6);
        run(4, -1);
        checks++; if (got.size() !== 2) begin errors++; $display("FAIL mid_pre_len got %0d exp 2", got.size()); end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL mid_key_valid got %b exp 0", bus.key_valid); end
        checks++; if (bus.key_byte !== 8'h00) begin errors++; $display("FAIL mid_key_byte got %h exp 00", bus.key_byte); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", bus.busy); end
        @(posedge clk); #1 rst = 1'b1;
        clear();
        run(10, -1);
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL mid_quiet_len got %0d exp 0", got.size()); end
        checks++; if (n_acc !== 0) begin errors++; $display("FAIL mid_quiet_triples got %0d exp 0", n_acc); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_quiet_busy got %b exp 0", bus.busy); end
        clear();
        do_start(18'd6);
        run(100, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL mid_restart_timeout got no done exp done"); end
        checks++; if (got.size() !== 6) begin errors++; $display("FAIL mid_restart_len got %0d exp 6", got.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got.size() <= i || got[i] !== seq[i]) begin errors++; $display("FAIL mid_restart_byte%0d got %h exp %h", i, got.size() > i ? got[i] : 8'hxx, seq[i]); end
        end
        checks++; if (n_acc !== 2) begin errors++; $display("FAIL mid_restart_triples got %0d exp 2", n_acc); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        clear();
        do_start(18'd3);
        run(50, 2);
        checks++; if (timed_out) begin errors++; $display("FAIL ign_timeout got no done exp done"); end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL ign_len got %0d exp 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got.size() <= i || got[i] !== seq[i]) begin errors++; $display("FAIL ign_byte%0d got %h exp %h", i, got.size() > i ? got[i] : 8'hxx, seq[i]); end
        end
        checks++; if (done_cyc !== 6) begin errors++; $display("FAIL ign_done_cycle got %0d exp 6", done_cyc); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_busy_after got %b exp 0", bus.busy); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.num_bytes = '0;
        bus.ex_valid = 1'b1;
        bus.EX1 = 23'h123456;
        bus.EX2 = 23'h654321;
        bus.EX3 = 23'h0ABCDE;
        bus.key_ready = 1'b1;
        test_reset();
        test_basic();
        test_truncate();
        test_zero();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keystream_gen.md
KEYSTREAM_GEN -- requirements
Module: keystream_gen

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have ports: start  in  1  begin a keystream of num_bytes bytes.
REQ-004 SHALL have ports: num_bytes  in  18  byte count, sampled on accepted start.
REQ-005 SHALL have ports: ex_valid  in  1  upstream mantissa triple valid.
REQ-006 SHALL have ports: EX1, EX2, EX3  in  23 each  chaotic-map mantissas.
REQ-007 SHALL have ports: ex_ready  out  1  triple accepted when ex_valid && ex_ready.
REQ-008 SHALL have ports: key_byte  out  8  FIFO head byte.
REQ-009 SHALL have ports: key_valid  out  1  FIFO non-empty.
REQ-010 SHALL have ports: key_ready  in  1  downstream pops when key_valid && key_ready.
REQ-011 SHALL have ports: busy  out  1  state != IDLE.
REQ-012 SHALL have ports: done  out  1  one-cycle pulse at stream end.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, EMIT, FLUSH.
REQ-014 IDLE: start with num_bytes != 0 SHALL load remaining = num_bytes and move to FETCH; start with num_bytes == 0 SHALL pulse done next cycle and stay in IDLE.
REQ-015 start outside IDLE SHALL be ignored.
REQ-016 ex_ready SHALL be 1 only in FETCH.
REQ-017 FETCH: on accept, SHALL register K0 = EX1[7:0]^EX2[15:8]^EX3[22:15], K1 = EX2[7:0]^EX3[15:8]^EX1[22:15], K2 = EX3[7:0]^EX1[15:8]^EX2[22:15]; set idx = 0; go to EMIT.
REQ-018 EMIT: each cycle the FIFO count < 4 (evaluated before any same-cycle pop), SHALL push K[idx], decrement remaining, and increment idx.
REQ-019 EMIT: a push that makes remaining == 0 SHALL go to FLUSH, discarding unsent bytes of the triple; otherwise a push with idx == 2 SHALL go to FETCH.
REQ-020 FLUSH: when the FIFO is empty, SHALL assert done for one cycle and go to IDLE.
REQ-021 SHALL use a 4-entry byte FIFO, show-ahead: key_byte = oldest entry whenever key_valid = 1.
REQ-022 Simultaneous push and pop SHALL both take effect; a push is blocked when count == 4 even if a pop occurs that cycle.
REQ-023 key_byte and FIFO contents SHALL hold while key_valid && !key_ready; byte order SHALL be preserved.
REQ-024 Latency: triple accepted at cycle t with empty FIFO -> K0 pushed at t+1 -> key_valid = 1, key_byte = K0 at t+2.
REQ-025 With key_ready held at 1, throughput SHALL be 3 bytes per 4 cycles (FETCH + 3 EMIT) when ex_valid is held at 1.
REQ-026 remaining SHALL never underflow; 18-bit count supports up to 262143 bytes.

Reset
REQ-027 rst = 0 SHALL asynchronously force: state IDLE, FIFO empty, key_valid 0, key_byte 0x00, ex_ready 0, busy 0, done 0, remaining 0, idx 0, K0..K2 0.
REQ-028 Reset mid-stream SHALL abandon the stream; no bytes SHALL emerge after rst is released until a new start.
REQ-029 Release of rst SHALL be followed by normal operation on the next rising edge.

Verification
REQ-030 num_bytes = 3, EX1 = 0x123456, EX2 = 0x654321, EX3 = 0x0ABCDE, key_ready = 1 -> bytes 0x00, 0xB9, 0x20, then a done pulse; exactly one triple is accepted.
REQ-031 num_bytes = 2 with the same triple -> bytes 0x00, 0xB9 only; 0x20 is discarded; done pulses; ex_ready is never reasserted.
REQ-032 num_bytes = 7, key_ready = 0 -> FIFO fills to 4, EMIT stalls, ex_ready = 0; raise key_ready -> all 7 bytes arrive in order (3 triples accepted) -> done.
REQ-033 start with num_bytes = 0 -> done pulses one cycle later; busy stays 0; ex_ready stays 0.
REQ-034 Assert rst = 0 after 2 of 6 bytes -> key_valid drops immediately; after release, no output until a new start; a fresh start reproduces the full sequence.
REQ-035 start pulsed during EMIT -> ignored; byte count and done timing are unchanged.
